// File: rtl/vec_marker_sync.sv
// vec_marker_sync
//   Frame aligner that sits after the 32-bit word classifier. It finds a
//   periodic marker word (0xabadface), acquires and tracks frame lock, and
//   forwards each payload word together with its position in the frame. In
//   HUNT it also asks the word assembler for a 16-bit slip whenever the
//   marker is split across two consecutive words.
//
// Ports
//   sys_clk      in   system clock
//   sys_rst_n    in   synchronous reset, active low
//   in_valid     in   code/data qualifier; nothing advances while low
//   in_code      in   class code: 00 marker, 01 "abad" half, 10 "face" half, 11 payload
//   in_data      in   classified word
//   out_valid    out  payload word present on out_data/out_index
//   out_data     out  payload word
//   out_index    out  payload position 0..FRAME_LEN-1
//   frame_start  out  1-cycle pulse: in-slot marker accepted while locked
//   locked       out  high in LOCKED and FLYWHEEL
//   slip_req     out  1-cycle pulse: straddled marker seen in HUNT
//   lock_lost    out  1-cycle pulse: FLYWHEEL -> HUNT
//
// All outputs are registered, so each word's results appear one cycle after it.

module vec_marker_sync #(
    parameter int FRAME_LEN = 16,
    parameter int LOCK_CNT  = 3,
    parameter int MISS_CNT  = 2,
    parameter int IDX_W     = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    input  logic [1:0]       in_code,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             frame_start,
    output logic             locked,
    output logic             slip_req,
    output logic             lock_lost
);

    localparam int SLOT_W = $clog2(FRAME_LEN + 1);
    localparam int HIT_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(MISS_CNT + 1);

    localparam logic [SLOT_W-1:0] MARK_SLOT = SLOT_W'(FRAME_LEN);
    localparam logic [HIT_W-1:0]  LOCK_V    = HIT_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_V    = MISS_W'(MISS_CNT);

    localparam logic [1:0] CODE_MARK = 2'b00;
    localparam logic [1:0] CODE_ABAD = 2'b01;
    localparam logic [1:0] CODE_FACE = 2'b10;

    typedef enum logic [1:0] {
        ST_HUNT     = 2'd0,
        ST_VERIFY   = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_FLYWHEEL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [HIT_W-1:0]    hits_q, hits_d;
    logic [MISS_W-1:0]   misses_q, misses_d;
    logic                half_q, half_d;     // previous valid word in HUNT was "abad"
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_data_q, out_data_d;
    logic [IDX_W-1:0]    out_index_q, out_index_d;
    logic                frame_start_q, frame_start_d;
    logic                locked_q, locked_d;
    logic                slip_req_q, slip_req_d;
    logic                lock_lost_q, lock_lost_d;

    logic                at_marker;
    logic                is_mark;
    logic [MISS_W-1:0]   miss_next;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        hits_d        = hits_q;
        misses_d      = misses_q;
        half_d        = half_q;
        out_valid_d   = 1'b0;
        out_data_d    = out_data_q;
        out_index_d   = out_index_q;
        frame_start_d = 1'b0;
        slip_req_d    = 1'b0;
        lock_lost_d   = 1'b0;

        // slot_q counts words since the last marker; when it has reached
        // FRAME_LEN the incoming word occupies the marker slot.
        at_marker = (slot_q == MARK_SLOT);
        is_mark   = (in_code == CODE_MARK);
        miss_next = (state_q == ST_LOCKED) ? MISS_W'(1) : misses_q + MISS_W'(1);

        if (in_valid) begin
            slot_d = at_marker ? '0 : slot_q + SLOT_W'(1);
            unique case (state_q)
                ST_HUNT: begin
                    slot_d = '0;
                    half_d = (in_code == CODE_ABAD);
                    if (is_mark) begin
                        half_d   = 1'b0;
                        hits_d   = HIT_W'(1);
                        misses_d = '0;
                        if (LOCK_CNT == 1) begin
                            state_d       = ST_LOCKED;
                            frame_start_d = 1'b1;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else if (half_q && (in_code == CODE_FACE)) begin
                        slip_req_d = 1'b1;
                    end
                end
                ST_VERIFY: begin
                    // Off-slot markers are deliberately ignored here.
                    if (at_marker) begin
                        if (is_mark) begin
                            hits_d = hits_q + HIT_W'(1);
                            if (hits_q + HIT_W'(1) == LOCK_V) begin
                                state_d       = ST_LOCKED;
                                misses_d      = '0;
                                frame_start_d = 1'b1;
                            end
                        end else begin
                            state_d = ST_HUNT;
                            hits_d  = '0;
                            slot_d  = '0;
                        end
                    end
                end
                default: begin  // ST_LOCKED, ST_FLYWHEEL
                    if (at_marker) begin
                        if (is_mark) begin
                            state_d       = ST_LOCKED;
                            misses_d      = '0;
                            frame_start_d = 1'b1;
                        end else if (miss_next == MISS_V) begin
                            state_d     = ST_HUNT;
                            lock_lost_d = 1'b1;
                            hits_d      = '0;
                            misses_d    = '0;
                            slot_d      = '0;
                            half_d      = 1'b0;
                        end else begin
                            state_d  = ST_FLYWHEEL;
                            misses_d = miss_next;
                        end
                    end else begin
                        // Payload is forwarded whatever its code says.
                        out_valid_d = 1'b1;
                        out_data_d  = in_data;
                        out_index_d = IDX_W'(slot_q);
                    end
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED) || (state_d == ST_FLYWHEEL);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q       <= ST_HUNT;
            slot_q        <= '0;
            hits_q        <= '0;
            misses_q      <= '0;
            half_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_index_q   <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            slip_req_q    <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            hits_q        <= hits_d;
            misses_q      <= misses_d;
            half_q        <= half_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_index_q   <= out_index_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            slip_req_q    <= slip_req_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_index   = out_index_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign slip_req    = slip_req_q;
    assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_vec_marker_sync.sv
// Directed bench for vec_marker_sync with FRAME_LEN=4, LOCK_CNT=3, MISS_CNT=2.
// Each step drives one input word on the falling edge and checks the
// registered outputs just after the following rising edge.

module tb_vec_marker_sync;

    localparam int IDX_W = 8;
    localparam logic [31:0] MARK = 32'habadface;
    localparam logic [31:0] BAD  = 32'h12345678;
    localparam logic [31:0] ABAD = 32'h0000abad;
    localparam logic [31:0] FACE = 32'hface0000;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             in_valid;
    logic [1:0]       in_code;
    logic [31:0]      in_data;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [IDX_W-1:0] out_index;
    logic             frame_start;
    logic             locked;
    logic             slip_req;
    logic             lock_lost;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int step_no = 0;

    vec_marker_sync #(
        .FRAME_LEN(4),
        .LOCK_CNT (3),
        .MISS_CNT (2),
        .IDX_W    (IDX_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_index  (out_index),
        .frame_start(frame_start),
        .locked     (locked),
        .slip_req   (slip_req),
        .lock_lost  (lock_lost)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    // Drive one word, then check every output against the expected values.
    task automatic xfer(input logic v, input logic [1:0] code, input logic [31:0] data,
                        input logic e_ov, input int e_idx, input logic e_fs,
                        input logic e_lk, input logic e_sr, input logic e_ll);
        @(negedge sys_clk);
        in_valid = v;
        in_code  = code;
        in_data  = data;
        @(posedge sys_clk);
        #1;
        step_no++;
        chk("out_valid",   32'(out_valid),   32'(e_ov));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("locked",      32'(locked),      32'(e_lk));
        chk("slip_req",    32'(slip_req),    32'(e_sr));
        chk("lock_lost",   32'(lock_lost),   32'(e_ll));
        if (e_ov) begin
            chk("out_data",  out_data,         data);
            chk("out_index", 32'(out_index),   32'(e_idx));
        end
    endtask

    task automatic mark_w(input logic e_fs, input logic e_lk);
        xfer(1'b1, 2'b00, MARK, 1'b0, 0, e_fs, e_lk, 1'b0, 1'b0);
    endtask

    // Four payload words; forwarded with indices 0..3 when fwd is set.
    task automatic payload4(input logic fwd, input logic e_lk, input logic [31:0] base);
        for (int i = 0; i < 4; i++)
            xfer(1'b1, 2'b11, base + 32'(i), fwd, i, 1'b0, e_lk, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ov"},  32'(out_valid),   32'd0);
        chk({tag, "_od"},  out_data,         32'd0);
        chk({tag, "_oi"},  32'(out_index),   32'd0);
        chk({tag, "_fs"},  32'(frame_start), 32'd0);
        chk({tag, "_lk"},  32'(locked),      32'd0);
        chk({tag, "_sr"},  32'(slip_req),    32'd0);
        chk({tag, "_ll"},  32'(lock_lost),   32'd0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        in_code   = 2'b11;
        in_data   = 32'd0;
        repeat (2) @(posedge sys_clk);
        #1;
        check_all_zero("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Acquisition: three in-slot markers lock, then tracking.
        mark_w(1'b0, 1'b0);
        payload4(1'b0, 1'b0, 32'h100);
        mark_w(1'b0, 1'b0);
        payload4(1'b0, 1'b0, 32'h110);
        mark_w(1'b1, 1'b1);
        payload4(1'b1, 1'b1, 32'h120);
        mark_w(1'b1, 1'b1);
        payload4(1'b1, 1'b1, 32'h130);

        // One missed marker: flywheel keeps lock and forwarding.
        xfer(1'b1, 2'b11, BAD, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        payload4(1'b1, 1'b1, 32'h140);
        mark_w(1'b1, 1'b1);
        payload4(1'b1, 1'b1, 32'h150);

        // Two consecutive misses drop lock.
        xfer(1'b1, 2'b11, BAD, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        payload4(1'b1, 1'b1, 32'h160);
        xfer(1'b1, 2'b11, BAD, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        payload4(1'b0, 1'b0, 32'h170);

        // Straddled marker in HUNT, then a non-adjacent pair.
        xfer(1'b1, 2'b01, ABAD, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 2'b10, FACE, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        xfer(1'b1, 2'b11, 32'h55, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 2'b01, ABAD, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 2'b11, 32'h66, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 2'b10, FACE, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // VERIFY: off-slot marker ignored, payload in marker slot aborts.
        mark_w(1'b0, 1'b0);
        xfer(1'b1, 2'b11, 32'h200, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        mark_w(1'b0, 1'b0);
        xfer(1'b1, 2'b11, 32'h201, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 2'b11, 32'h202, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 2'b11, 32'h203, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Back in HUNT: a full three markers are needed again.
        mark_w(1'b0, 1'b0);
        payload4(1'b0, 1'b0, 32'h210);
        mark_w(1'b0, 1'b0);
        payload4(1'b0, 1'b0, 32'h220);
        mark_w(1'b1, 1'b1);

        // Gapped stream: same indices and pulses, idle cycles are quiet.
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 2'b11, 32'h300 + 32'(i), 1'b1, i, 1'b0, 1'b1, 1'b0, 1'b0);
            xfer(1'b0, 2'b00, MARK, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        mark_w(1'b1, 1'b1);
        xfer(1'b0, 2'b11, 32'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        xfer(1'b1, 2'b11, 32'h310, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 2'b11, 32'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        xfer(1'b1, 2'b11, 32'h311, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-frame while a word is presented.
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'b11;
        in_data   = 32'h312;
        @(posedge sys_clk);
        #1;
        check_all_zero("midrst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        in_valid  = 1'b0;

        mark_w(1'b0, 1'b0);
        payload4(1'b0, 1'b0, 32'h400);
        mark_w(1'b0, 1'b0);
        payload4(1'b0, 1'b0, 32'h410);
        mark_w(1'b1, 1'b1);
        payload4(1'b1, 1'b1, 32'h420);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
